// File: rtl/stage5_hazard_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage5_hazard_unit_pkg : shared types for the stage5 hazard/redirect unit
// Rev 1.0
// ----------------------------------------------------------------------------
package stage5_hazard_unit_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    PC_4      = 2'd0,
    PC_BRANCH = 2'd1,
    PC_EXC    = 2'd2,
    PC_FENCE  = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    ST_RUN           = 2'd0,
    ST_REDIRECT_WAIT = 2'd1,
    ST_FENCE_DRAIN   = 2'd2,
    ST_FENCE_FLUSH   = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_wb;
  } hz_ctl_t;

  localparam hz_ctl_t HZ_CTL_NONE = '0;

  // A zero-length drain still needs a one-bit counter to stay legal.
  function automatic int unsigned cnt_width(input int unsigned drain);
    return (drain == 0) ? 1 : $clog2(drain + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage5_hazard_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage5_hazard_unit_if : pipeline <-> hazard unit control bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface stage5_hazard_unit_if;
  import stage5_hazard_unit_pkg::*;

  logic [REG_W-1:0] rs1_d;
  logic [REG_W-1:0] rs2_d;
  logic             rs1_used_d;
  logic             rs2_used_d;
  logic [REG_W-1:0] rd_e;
  logic             load_e;
  logic             mispredict_e;
  logic             exception_m;
  logic             dmem_busy_m;
  logic             imem_busy_f;
  logic             fence_i_d;
  logic             icache_flush_done;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flush_wb;
  logic             icache_flush;
  pc_sel_t          pc_sel;
  logic             busy;

  modport master (
    output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_e, load_e,
    output mispredict_e, exception_m, dmem_busy_m, imem_busy_f,
    output fence_i_d, icache_flush_done,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_wb,
    input  icache_flush, pc_sel, busy
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_e, load_e,
    input  mispredict_e, exception_m, dmem_busy_m, imem_busy_f,
    input  fence_i_d, icache_flush_done,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_wb,
    output icache_flush, pc_sel, busy
  );

endinterface
`default_nettype wire

// File: rtl/stage5_load_use_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage5_load_use_detect : decode source vs. execute load destination match
// Rev 1.0
// ----------------------------------------------------------------------------
module stage5_load_use_detect
  import stage5_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             load_e,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = rs1_used_d && (rs1_d == rd_e);
    rs2_hit  = rs2_used_d && (rs2_d == rd_e);
    // x0 is hardwired, so a load targeting it never creates a dependency.
    load_use = load_e && (rd_e != '0) && (rs1_hit || rs2_hit);
  end

endmodule
`default_nettype wire

// File: rtl/stage5_hazard_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage5_hazard_unit : stall/flush/redirect control with fence.i sequencing
// Rev 1.0
// ----------------------------------------------------------------------------
module stage5_hazard_unit
  import stage5_hazard_unit_pkg::*;
#(
  parameter int unsigned FENCE_DRAIN = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  stage5_hazard_unit_if.slave  hz
);

  localparam int unsigned      CNT_W      = cnt_width(FENCE_DRAIN);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FENCE_DRAIN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  hz_state_t        state_q;
  hz_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             busy_d;
  hz_ctl_t          ctl;
  pc_sel_t          pc_sel_w;
  logic             load_use;

  stage5_load_use_detect u_load_use (
    .rs1_d      (hz.rs1_d),
    .rs2_d      (hz.rs2_d),
    .rs1_used_d (hz.rs1_used_d),
    .rs2_used_d (hz.rs2_used_d),
    .rd_e       (hz.rd_e),
    .load_e     (hz.load_e),
    .load_use   (load_use)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctl      = HZ_CTL_NONE;
    pc_sel_w = PC_4;

    if (hz.exception_m) begin
      // Exceptions pre-empt every sequence in every state.
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
      ctl.flush_m = 1'b1;
      pc_sel_w    = PC_EXC;
      state_d     = ST_RUN;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hz.dmem_busy_m) begin
            ctl.stall_f  = 1'b1;
            ctl.stall_d  = 1'b1;
            ctl.stall_e  = 1'b1;
            ctl.stall_m  = 1'b1;
            ctl.flush_wb = 1'b1;
          end else if (hz.mispredict_e) begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
            pc_sel_w    = PC_BRANCH;
            if (hz.imem_busy_f) state_d = ST_REDIRECT_WAIT;
          end else if (load_use) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
          end else if (hz.fence_i_d) begin
            if (FENCE_DRAIN == 0) begin
              state_d = ST_FENCE_FLUSH;
            end else begin
              state_d = ST_FENCE_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end else if (hz.imem_busy_f) begin
            ctl.stall_f = 1'b1;
            ctl.flush_d = 1'b1;
          end
        end

        ST_REDIRECT_WAIT: begin
          // Keep killing the stale fetch until the I-side accepts the new PC.
          ctl.flush_d = 1'b1;
          if (!hz.imem_busy_f) state_d = ST_RUN;
        end

        ST_FENCE_DRAIN: begin
          ctl.stall_f = 1'b1;
          ctl.stall_d = 1'b1;
          ctl.flush_e = 1'b1;
          if (hz.dmem_busy_m) begin
            ctl.stall_e  = 1'b1;
            ctl.stall_m  = 1'b1;
            ctl.flush_wb = 1'b1;
          end else begin
            cnt_d = (cnt_q != '0) ? (cnt_q - CNT_ONE) : '0;
            if (cnt_q <= CNT_ONE) state_d = ST_FENCE_FLUSH;
          end
        end

        ST_FENCE_FLUSH: begin
          if (hz.icache_flush_done) begin
            ctl.flush_d = 1'b1;
            pc_sel_w    = PC_FENCE;
            state_d     = ST_RUN;
          end else begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Reset masks every control output so a half-finished sequence cannot leak.
  always_comb begin
    hz.stall_f      = ctl.stall_f  & ~RST;
    hz.stall_d      = ctl.stall_d  & ~RST;
    hz.stall_e      = ctl.stall_e  & ~RST;
    hz.stall_m      = ctl.stall_m  & ~RST;
    hz.flush_d      = ctl.flush_d  & ~RST;
    hz.flush_e      = ctl.flush_e  & ~RST;
    hz.flush_m      = ctl.flush_m  & ~RST;
    hz.flush_wb     = ctl.flush_wb & ~RST;
    hz.icache_flush = (state_q == ST_FENCE_FLUSH) & ~RST;
    hz.pc_sel       = RST ? PC_4 : pc_sel_w;
    hz.busy         = busy_q & ~RST;
  end

endmodule
`default_nettype wire

// File: tb/tb_stage5_hazard_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stage5_hazard_unit : directed scenarios plus randomized model comparison
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stage5_hazard_unit;
  import stage5_hazard_unit_pkg::*;

  localparam int TB_DRAIN = 3;

  // Control vector order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_wb
  localparam logic [7:0] C_NONE     = 8'b0000_0000;
  localparam logic [7:0] C_LU       = 8'b1100_0100;
  localparam logic [7:0] C_EXC      = 8'b0000_1110;
  localparam logic [7:0] C_MISP     = 8'b0000_1100;
  localparam logic [7:0] C_FD       = 8'b0000_1000;
  localparam logic [7:0] C_DRAIN    = 8'b1100_0100;
  localparam logic [7:0] C_DRAIN_DM = 8'b1111_0101;
  localparam logic [7:0] C_DMEM     = 8'b1111_0001;
  localparam logic [7:0] C_SFD      = 8'b1100_0000;
  localparam logic [7:0] C_IMEM     = 8'b1000_1000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  stage5_hazard_unit_if hz ();

  stage5_hazard_unit #(.FENCE_DRAIN(TB_DRAIN)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  // Reference model state: what sequence is in flight, in plain terms.
  bit m_redirect;
  bit m_flushing;
  int m_drain_left;

  function automatic logic [7:0] obs();
    return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
            hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_wb};
  endfunction

  task automatic clear_inputs();
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_used_d = 0; hz.rs2_used_d = 0;
    hz.rd_e = '0; hz.load_e = 0; hz.mispredict_e = 0; hz.exception_m = 0;
    hz.dmem_busy_m = 0; hz.imem_busy_f = 0; hz.fence_i_d = 0;
    hz.icache_flush_done = 0;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void model_step(output logic [7:0] e_ctl, output pc_sel_t e_pc,
                                     output logic e_icf, output logic e_busy);
    logic lu;
    lu = hz.load_e && (hz.rd_e != 0) &&
         ((hz.rs1_used_d && hz.rs1_d == hz.rd_e) || (hz.rs2_used_d && hz.rs2_d == hz.rd_e));
    e_ctl  = C_NONE;
    e_pc   = PC_4;
    e_icf  = 1'b0;
    e_busy = !RST && (m_redirect || m_flushing || m_drain_left > 0);
    if (RST) begin
      m_redirect = 0; m_flushing = 0; m_drain_left = 0;
    end else begin
      e_icf = m_flushing;
      if (hz.exception_m) begin
        e_ctl = C_EXC; e_pc = PC_EXC;
        m_redirect = 0; m_flushing = 0; m_drain_left = 0;
      end else if (m_redirect) begin
        e_ctl = C_FD;
        m_redirect = hz.imem_busy_f;
      end else if (m_drain_left > 0) begin
        if (hz.dmem_busy_m) e_ctl = C_DRAIN_DM;
        else begin
          e_ctl = C_DRAIN;
          m_drain_left--;
          if (m_drain_left == 0) m_flushing = 1;
        end
      end else if (m_flushing) begin
        if (hz.icache_flush_done) begin
          e_ctl = C_FD; e_pc = PC_FENCE; m_flushing = 0;
        end else e_ctl = C_SFD;
      end else if (hz.dmem_busy_m) e_ctl = C_DMEM;
      else if (hz.mispredict_e) begin
        e_ctl = C_MISP; e_pc = PC_BRANCH; m_redirect = hz.imem_busy_f;
      end else if (lu) e_ctl = C_LU;
      else if (hz.fence_i_d) begin
        m_drain_left = TB_DRAIN;
        if (TB_DRAIN == 0) m_flushing = 1;
      end else if (hz.imem_busy_f) e_ctl = C_IMEM;
    end
  endfunction

  task automatic test_reset();
    RST = 1;
    clear_inputs();
    hz.exception_m = 1; hz.mispredict_e = 1; hz.imem_busy_f = 1; hz.dmem_busy_m = 1;
    hz.load_e = 1; hz.rd_e = 5'd3; hz.rs1_d = 5'd3; hz.rs1_used_d = 1;
    settle();
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL reset_ctl got %b want %b", obs(), C_NONE); end
    vectors++; if (hz.pc_sel !== PC_4) begin miscompares++; $display("FAIL reset_pc got %0d want %0d", hz.pc_sel, PC_4); end
    vectors++; if (hz.icache_flush !== 1'b0) begin miscompares++; $display("FAIL reset_icf got %b want 0", hz.icache_flush); end
    vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", hz.busy); end
    tick();
    tick();
    RST = 0;
    clear_inputs();
    settle();
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL idle_ctl got %b want %b", obs(), C_NONE); end
    vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", hz.busy); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.load_e = 1; hz.rd_e = 5'd5; hz.rs2_d = 5'd5; hz.rs2_used_d = 1;
    settle();
    vectors++; if (obs() !== C_LU) begin miscompares++; $display("FAIL lu_rs2 got %b want %b", obs(), C_LU); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL lu_after got %b want %b", obs(), C_NONE); end
    tick();
    hz.load_e = 1; hz.rd_e = 5'd0; hz.rs1_d = 5'd0; hz.rs1_used_d = 1; hz.rs2_d = 5'd0; hz.rs2_used_d = 1;
    settle();
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL lu_x0 got %b want %b", obs(), C_NONE); end
    tick();
    clear_inputs();
    hz.load_e = 1; hz.rd_e = 5'd7; hz.rs1_d = 5'd7; hz.rs1_used_d = 1;
    settle();
    vectors++; if (obs() !== C_LU) begin miscompares++; $display("FAIL lu_rs1 got %b want %b", obs(), C_LU); end
    tick();
    hz.rs1_used_d = 0;
    settle();
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL lu_unused got %b want %b", obs(), C_NONE); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mispredict_held();
    int n_fd = 0;
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      hz.mispredict_e = (c == 0);
      hz.imem_busy_f  = (c < 3);
      settle();
      if (hz.flush_d) n_fd++;
      if (c == 0) begin
        vectors++; if (obs() !== C_MISP) begin miscompares++; $display("FAIL misp_ctl got %b want %b", obs(), C_MISP); end
        vectors++; if (hz.pc_sel !== PC_BRANCH) begin miscompares++; $display("FAIL misp_pc got %0d want %0d", hz.pc_sel, PC_BRANCH); end
      end
      if (c == 2) begin
        vectors++; if (hz.pc_sel !== PC_4) begin miscompares++; $display("FAIL misp_wait_pc got %0d want %0d", hz.pc_sel, PC_4); end
        vectors++; if (hz.busy !== 1'b1) begin miscompares++; $display("FAIL misp_wait_busy got %b want 1", hz.busy); end
      end
      if (c == 4) begin
        vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL misp_run_busy got %b want 0", hz.busy); end
        vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL misp_run_ctl got %b want %b", obs(), C_NONE); end
      end
      tick();
    end
    vectors++; if (n_fd !== 4) begin miscompares++; $display("FAIL misp_flush_d_cycles got %0d want 4", n_fd); end
    clear_inputs();
  endtask

  task automatic test_fence();
    int n_fe = 0, n_icf = 0, n_pcf = 0, n_busy = 0;
    clear_inputs();
    for (int c = 0; c < 12; c++) begin
      hz.fence_i_d = (c == 0);
      hz.icache_flush_done = hz.icache_flush && (n_icf == 2);
      settle();
      if (hz.flush_e) n_fe++;
      if (hz.icache_flush) n_icf++;
      if (hz.pc_sel === PC_FENCE) n_pcf++;
      if (hz.busy) n_busy++;
      if (c == 1) begin
        vectors++; if (obs() !== C_DRAIN) begin miscompares++; $display("FAIL fence_drain_ctl got %b want %b", obs(), C_DRAIN); end
      end
      tick();
    end
    vectors++; if (n_fe !== 3) begin miscompares++; $display("FAIL fence_flush_e got %0d want 3", n_fe); end
    vectors++; if (n_icf !== 3) begin miscompares++; $display("FAIL fence_icf got %0d want 3", n_icf); end
    vectors++; if (n_pcf !== 1) begin miscompares++; $display("FAIL fence_pcf got %0d want 1", n_pcf); end
    vectors++; if (n_busy !== 6) begin miscompares++; $display("FAIL fence_busy_cycles got %0d want 6", n_busy); end
    vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL fence_end_busy got %b want 0", hz.busy); end
    clear_inputs();
  endtask

  task automatic test_exception_priority();
    bit found = 0;
    clear_inputs();
    hz.exception_m = 1; hz.dmem_busy_m = 1; hz.mispredict_e = 1;
    hz.load_e = 1; hz.rd_e = 5'd9; hz.rs1_d = 5'd9; hz.rs1_used_d = 1;
    settle();
    vectors++; if (obs() !== C_EXC) begin miscompares++; $display("FAIL exc_ctl got %b want %b", obs(), C_EXC); end
    vectors++; if (hz.pc_sel !== PC_EXC) begin miscompares++; $display("FAIL exc_pc got %0d want %0d", hz.pc_sel, PC_EXC); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL exc_busy got %b want 0", hz.busy); end
    tick();
    // Exception aborting a redirect wait.
    hz.mispredict_e = 1; hz.imem_busy_f = 1;
    settle(); tick();
    hz.mispredict_e = 0; hz.exception_m = 1;
    settle();
    vectors++; if (obs() !== C_EXC) begin miscompares++; $display("FAIL exc_redir_ctl got %b want %b", obs(), C_EXC); end
    tick();
    hz.exception_m = 0;
    settle();
    vectors++; if (obs() !== C_IMEM) begin miscompares++; $display("FAIL exc_redir_after got %b want %b", obs(), C_IMEM); end
    tick();
    // Exception aborting the I-cache flush.
    clear_inputs();
    hz.fence_i_d = 1;
    for (int c = 0; c < 8 && !found; c++) begin
      settle();
      if (hz.icache_flush) found = 1;
      else begin tick(); hz.fence_i_d = 0; end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL exc_fence_timeout got 0 want 1"); end
    hz.exception_m = 1;
    #1;
    vectors++; if (hz.pc_sel !== PC_EXC) begin miscompares++; $display("FAIL exc_fence_pc got %0d want %0d", hz.pc_sel, PC_EXC); end
    tick();
    hz.exception_m = 0;
    settle();
    vectors++; if (hz.icache_flush !== 1'b0) begin miscompares++; $display("FAIL exc_fence_icf got %b want 0", hz.icache_flush); end
    vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL exc_fence_busy got %b want 0", hz.busy); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_fence();
    int n_icf = 0, n_pcf = 0;
    clear_inputs();
    hz.fence_i_d = 1;
    settle(); tick();
    hz.fence_i_d = 0;
    settle(); tick();
    RST = 1;
    settle();
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL rstmid_ctl got %b want %b", obs(), C_NONE); end
    tick();
    RST = 0;
    settle();
    vectors++; if (hz.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", hz.busy); end
    vectors++; if (obs() !== C_NONE) begin miscompares++; $display("FAIL rstmid_run got %b want %b", obs(), C_NONE); end
    tick();
    hz.icache_flush_done = 1;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (hz.icache_flush) n_icf++;
      if (hz.pc_sel === PC_FENCE) n_pcf++;
      tick();
    end
    vectors++; if (n_icf !== 0) begin miscompares++; $display("FAIL rstmid_icf got %0d want 0", n_icf); end
    vectors++; if (n_pcf !== 0) begin miscompares++; $display("FAIL rstmid_pcf got %0d want 0", n_pcf); end
    clear_inputs();
  endtask

  task automatic test_dmem_during_fence();
    int n_fe = 0, n_sm = 0, n_wb = 0, n_icf = 0, n_pcf = 0;
    clear_inputs();
    for (int c = 0; c < 16; c++) begin
      hz.fence_i_d = (c == 0);
      hz.dmem_busy_m = (c >= 2 && c <= 5);
      hz.icache_flush_done = hz.icache_flush && (n_icf == 2);
      settle();
      if (hz.flush_e) n_fe++;
      if (hz.stall_m) n_sm++;
      if (hz.flush_wb) n_wb++;
      if (hz.icache_flush) n_icf++;
      if (hz.pc_sel === PC_FENCE) n_pcf++;
      if (c == 3) begin
        vectors++; if (obs() !== C_DRAIN_DM) begin miscompares++; $display("FAIL dm_drain_ctl got %b want %b", obs(), C_DRAIN_DM); end
      end
      tick();
    end
    vectors++; if (n_fe !== 7) begin miscompares++; $display("FAIL dm_drain_len got %0d want 7", n_fe); end
    vectors++; if (n_sm !== 4) begin miscompares++; $display("FAIL dm_stall_m got %0d want 4", n_sm); end
    vectors++; if (n_wb !== 4) begin miscompares++; $display("FAIL dm_flush_wb got %0d want 4", n_wb); end
    vectors++; if (n_icf !== 3) begin miscompares++; $display("FAIL dm_icf got %0d want 3", n_icf); end
    vectors++; if (n_pcf !== 1) begin miscompares++; $display("FAIL dm_pcf got %0d want 1", n_pcf); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [7:0] e_ctl;
    pc_sel_t    e_pc;
    logic       e_icf, e_busy;
    for (int c = 0; c < 600; c++) begin
      RST                  = (c == 0) || ($urandom_range(0, 63) == 0);
      hz.exception_m       = ($urandom_range(0, 15) == 0);
      hz.dmem_busy_m       = ($urandom_range(0, 4) == 0);
      hz.mispredict_e      = ($urandom_range(0, 5) == 0);
      hz.imem_busy_f       = ($urandom_range(0, 2) == 0);
      hz.fence_i_d         = ($urandom_range(0, 7) == 0);
      hz.icache_flush_done = ($urandom_range(0, 2) == 0);
      hz.load_e            = ($urandom_range(0, 2) == 0);
      hz.rd_e              = 5'($urandom_range(0, 3));
      hz.rs1_d             = 5'($urandom_range(0, 3));
      hz.rs2_d             = 5'($urandom_range(0, 3));
      hz.rs1_used_d        = $urandom_range(0, 1) != 0;
      hz.rs2_used_d        = $urandom_range(0, 1) != 0;
      settle();
      model_step(e_ctl, e_pc, e_icf, e_busy);
      vectors++; if (obs() !== e_ctl) begin miscompares++; $display("FAIL rnd_ctl c=%0d got %b want %b", c, obs(), e_ctl); end
      vectors++; if (hz.pc_sel !== e_pc) begin miscompares++; $display("FAIL rnd_pc c=%0d got %0d want %0d", c, hz.pc_sel, e_pc); end
      vectors++; if (hz.icache_flush !== e_icf) begin miscompares++; $display("FAIL rnd_icf c=%0d got %b want %b", c, hz.icache_flush, e_icf); end
      vectors++; if (hz.busy !== e_busy) begin miscompares++; $display("FAIL rnd_busy c=%0d got %b want %b", c, hz.busy, e_busy); end
      tick();
    end
    RST = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_mispredict_held();
    test_fence();
    test_exception_priority();
    test_reset_mid_fence();
    test_dmem_during_fence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage5_hazard_unit.md
STAGE5_HAZARD_UNIT -- requirements
Module: stage5_hazard_unit

Interface
REQ-001 The block SHALL have parameter FENCE_DRAIN, default 3, giving the number of bubble cycles before an I-cache flush on fence.i.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: the block's only clock.
- RST, in, 1: reset, synchronous, active-high.
- rs1_d / rs2_d, in, 5 each: decode source registers.
- rs1_used_d / rs2_used_d, in, 1 each: decode reads that source.
- rd_e, in, 5: execute destination register.
- load_e, in, 1: execute holds a load.
- mispredict_e, in, 1: branch or jump resolved wrong in execute.
- exception_m, in, 1: memory-stage exception or interrupt commit.
- dmem_busy_m, in, 1: D-memory access pending.
- imem_busy_f, in, 1: I-fetch pending.
- fence_i_d, in, 1: fence.i in decode.
- icache_flush_done, in, 1: I-cache flush complete.
- stall_f, stall_d, stall_e, stall_m, out, 1 each: hold the stage register.
- flush_d, flush_e, flush_m, flush_wb, out, 1 each: insert a bubble into the stage register.
- icache_flush, out, 1: flush request to the I-cache.
- pc_sel, out, pc_sel_t: next-PC source.
- busy, out, 1: FSM not in RUN.

Function
REQ-003 The FSM SHALL use states RUN, REDIRECT_WAIT, FENCE_DRAIN and FENCE_FLUSH.
REQ-004 In RUN, the block SHALL evaluate conditions in this priority: exception_m, then dmem_busy_m, then mispredict_e, then load-use, then fence_i_d, then imem_busy_f.
REQ-005 On exception_m, the block SHALL assert flush_d, flush_e and flush_m with pc_sel=PC_EXC in the same cycle, and the next state SHALL be RUN.
REQ-006 exception_m SHALL have this effect in every state, aborting any fence or redirect sequence and deasserting icache_flush the next cycle.
REQ-007 On dmem_busy_m, the block SHALL assert stall_f, stall_d, stall_e, stall_m and flush_wb; no other action SHALL be taken that cycle; a pending mispredict_e is re-evaluated once busy drops.
REQ-008 On mispredict_e, the block SHALL assert flush_d and flush_e with pc_sel=PC_BRANCH.
REQ-009 If imem_busy_f is high in the same cycle as mispredict_e, the block SHALL enter REDIRECT_WAIT.
REQ-010 In REDIRECT_WAIT, the block SHALL assert flush_d each cycle until the cycle imem_busy_f is low, then return to RUN; pc_sel SHALL be PC_4 in this state.
REQ-011 Load-use SHALL be defined as load_e and rd_e!=0 and ((rs1_used_d and rs1_d==rd_e) or (rs2_used_d and rs2_d==rd_e)).
REQ-012 Load-use SHALL assert stall_f, stall_d and flush_e for exactly that cycle, giving a one-bubble latency.
REQ-013 On fence_i_d with no higher-priority condition, the block SHALL load a down-counter with FENCE_DRAIN and enter FENCE_DRAIN.
REQ-014 In FENCE_DRAIN, the block SHALL assert stall_f, stall_d and flush_e and decrement the counter each cycle; when the counter reaches 1 it SHALL go to FENCE_FLUSH.
REQ-015 In FENCE_FLUSH, the block SHALL hold icache_flush=1, stall_f and stall_d until icache_flush_done.
REQ-016 In the icache_flush_done cycle, the block SHALL drive pc_sel=PC_FENCE and flush_d for one cycle and return to RUN.
REQ-017 If FENCE_DRAIN=0, the block SHALL go directly from RUN to FENCE_FLUSH.
REQ-018 The counter SHALL be $clog2(FENCE_DRAIN+1) bits wide and saturate at 0.
REQ-019 dmem_busy_m during FENCE_DRAIN SHALL freeze the counter and add stall_e, stall_m and flush_wb.
REQ-020 On imem_busy_f alone, the block SHALL assert stall_f and flush_d.
REQ-021 With no condition present, all stall and flush outputs SHALL be 0 and pc_sel SHALL be PC_4.
REQ-022 All stall and flush outputs SHALL be combinational from the state and inputs, with no added latency.
REQ-023 busy SHALL be registered from the state.

Reset
REQ-024 When RST=1 at a CLK edge, the state SHALL become RUN and the counter 0.
REQ-025 While RST=1, the block SHALL drive busy=0 and icache_flush=0, and pc_sel=PC_4.
REQ-026 While RST=1, the stall and flush outputs SHALL be 0.
REQ-027 Reset asserted mid-fence or mid-redirect SHALL abandon the sequence without issuing PC_FENCE.

Structure
REQ-028 pc_sel_t SHALL be a 2-bit enum (PC_4=0, PC_BRANCH=1, PC_EXC=2, PC_FENCE=3) defined in the shared stage5 package.
REQ-029 hz_state_t SHALL also be defined in the shared stage5 package.
REQ-030 The load-use comparator SHALL be a sub-module named stage5_load_use_detect.
REQ-031 The FSM and counter SHALL live in the top module.

Verification
REQ-032 The bench SHALL cover load-use: load_e=1, rd_e=5, rs2_d=5, rs2_used_d=1 -> one cycle of stall_f=stall_d=flush_e=1, then all 0; rd_e=0 -> no stall.
REQ-033 The bench SHALL cover a held mispredict: mispredict_e with imem_busy_f=1 for 3 cycles -> pc_sel=PC_BRANCH in the first cycle, flush_d high 4 cycles, RUN on the cycle after busy drops.
REQ-034 The bench SHALL cover fence.i: fence_i_d, FENCE_DRAIN=3, icache_flush_done after 2 cycles -> 3 flush_e cycles, icache_flush high 3 cycles, pc_sel=PC_FENCE once, busy then 0.
REQ-035 The bench SHALL cover exception priority: exception_m in the same cycle as dmem_busy_m, mispredict_e and load-use -> only flush_d, flush_e and flush_m with PC_EXC; no stalls.
REQ-036 The bench SHALL cover reset mid-fence: RST in the second FENCE_DRAIN cycle -> RUN next edge, icache_flush=0, no PC_FENCE.
REQ-037 The bench SHALL cover a D-memory wait: dmem_busy_m for 4 cycles during FENCE_DRAIN -> counter frozen, 4 cycles of stall_m and flush_wb, and drain length extended by 4.
